// File: rtl/rb_width_packer.sv
// rb_width_packer: packs RATIO narrow beats into one wide word.
// Early s_last flushes a partial word with per-lane keep bits.
module rb_width_packer #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4,
    parameter int OUT_W = IN_W * RATIO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic [RATIO-1:0] m_keep,
    output logic             m_last,
    output logic             partial
);

    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [0:0] ACC  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic [RATIO-1:0] keep_q, keep_d;
    logic             last_q, last_d;
    logic [RATIO-1:0] lane_oh;
    logic             accept;
    logic             last_lane;

    assign m_valid   = (state_q == HOLD);
    assign s_ready   = (state_q == ACC) | m_ready;
    assign accept    = s_valid & s_ready;
    assign last_lane = (idx_q == IDX_W'(RATIO - 1));
    assign m_data    = data_q;
    assign m_keep    = keep_q;
    assign m_last    = last_q;
    assign partial   = (idx_q != '0) && (state_q == ACC);

    // One-hot decode of the lane the next beat lands in
    always_comb begin
        lane_oh = '0;
        for (int k = 0; k < RATIO; k++) begin
            lane_oh[k] = (idx_q == IDX_W'(k));
        end
    end

    // Next-state: assemble lanes in ACC, present/consume word in HOLD
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        case (state_q)
            ACC: begin
                if (accept) begin
                    for (int k = 0; k < RATIO; k++) begin
                        if (lane_oh[k]) begin
                            data_d[k*IN_W +: IN_W] = s_data;
                        end
                    end
                    keep_d = keep_q | lane_oh;
                    if (last_lane || s_last) begin
                        state_d = HOLD;
                        last_d  = s_last;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    // Word leaves; a same-cycle beat starts a fresh word
                    data_d  = '0;
                    keep_d  = '0;
                    last_d  = 1'b0;
                    idx_d   = '0;
                    state_d = ACC;
                    if (accept) begin
                        data_d[IN_W-1:0] = s_data;
                        keep_d[0]        = 1'b1;
                        if (s_last || RATIO == 1) begin
                            state_d = HOLD;
                            last_d  = s_last;
                        end else begin
                            idx_d = IDX_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    // State registers, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            idx_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_rb_width_packer.sv
// Testbench for rb_width_packer: 8x4 vector table and sequences,
// plus a 16x1 instance checked against a scoreboard queue.
module tb_rb_width_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_s_valid, a_s_ready, a_s_last;
    logic [7:0]  a_s_data;
    logic        a_m_valid, a_m_ready, a_m_last, a_partial;
    logic [31:0] a_m_data;
    logic [3:0]  a_m_keep;

    logic        b_s_valid, b_s_ready, b_s_last;
    logic [15:0] b_s_data;
    logic        b_m_valid, b_m_ready, b_m_last, b_partial;
    logic [15:0] b_m_data;
    logic [0:0]  b_m_keep;

    rb_width_packer #(.IN_W(8), .RATIO(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(a_s_valid), .s_ready(a_s_ready),
        .s_data(a_s_data), .s_last(a_s_last),
        .m_valid(a_m_valid), .m_ready(a_m_ready),
        .m_data(a_m_data), .m_keep(a_m_keep),
        .m_last(a_m_last), .partial(a_partial)
    );

    rb_width_packer #(.IN_W(16), .RATIO(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(b_s_valid), .s_ready(b_s_ready),
        .s_data(b_s_data), .s_last(b_s_last),
        .m_valid(b_m_valid), .m_ready(b_m_ready),
        .m_data(b_m_data), .m_keep(b_m_keep),
        .m_last(b_m_last), .partial(b_partial)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sv;
        logic [7:0]  sd;
        logic        sl;
        logic        mr;
        logic        e_srdy;
        logic        e_mv;
        logic [31:0] e_md;
        logic [3:0]  e_mk;
        logic        e_ml;
        logic        e_pt;
    } vec_t;

    vec_t tbl[21];

    // Drive one cycle on dut; srdy is s_ready seen mid-cycle
    task automatic drive_a(input logic sv, input logic [7:0] sd,
                           input logic sl, input logic mr,
                           output logic srdy);
        a_s_valid = sv;
        a_s_data  = sd;
        a_s_last  = sl;
        a_m_ready = mr;
        @(negedge clk);
        srdy = a_s_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic mv,
                           input logic [31:0] md, input logic [3:0] mk,
                           input logic ml, input logic pt);
        check({tag, " m_valid"}, 64'(a_m_valid), 64'(mv));
        check({tag, " m_data"},  64'(a_m_data),  64'(md));
        check({tag, " m_keep"},  64'(a_m_keep),  64'(mk));
        check({tag, " m_last"},  64'(a_m_last),  64'(ml));
        check({tag, " partial"}, 64'(a_partial), 64'(pt));
    endtask

    logic [16:0] sb_q[$];
    logic [16:0] exp_item;
    logic        srdy;
    logic [31:0] held;
    int          sent;
    int          got;
    int          cyc;
    logic        prev_stall;
    logic [16:0] prev_word;

    initial begin
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h11,       4'h1, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2211,     4'h3, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h332211,   4'h7, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 32'h55,       4'h1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 32'h6655,     4'h3, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 32'h776655,   4'h7, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 8'h88, 1'b0, 1'b1, 1'b1, 1'b1, 32'h88776655, 4'hF, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA1,       4'h1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA2A1,     4'h3, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 8'hB0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hB0,       4'h1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 32'hB0,       4'h1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 8'hB1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hB1B0,     4'h3, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 32'hC3,       4'h1, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 8'hD0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hD0,       4'h1, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 8'hD1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hD1D0,     4'h3, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 8'hD2, 1'b0, 1'b1, 1'b1, 1'b0, 32'hD2D1D0,   4'h7, 1'b0, 1'b1};
        tbl[18] = '{1'b1, 8'hD3, 1'b1, 1'b1, 1'b1, 1'b1, 32'hD3D2D1D0, 4'hF, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'hD3D2D1D0, 4'hF, 1'b1, 1'b0};
        tbl[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        a_s_valid = 1'b0; a_s_data = '0; a_s_last = 1'b0; a_m_ready = 1'b0;
        b_s_valid = 1'b0; b_s_data = '0; b_s_last = 1'b0; b_m_ready = 1'b0;
        #12;
        check_a("reset", 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        check("reset s_ready", 64'(a_s_ready), 64'd1);
        check("reset dut1 m_valid", 64'(b_m_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 21; i++) begin
            drive_a(tbl[i].sv, tbl[i].sd, tbl[i].sl, tbl[i].mr, srdy);
            check($sformatf("vec%0d s_ready", i), 64'(srdy),
                  64'(tbl[i].e_srdy));
            check_a($sformatf("vec%0d", i), tbl[i].e_mv, tbl[i].e_md,
                    tbl[i].e_mk, tbl[i].e_ml, tbl[i].e_pt);
        end

        // Backpressure: word held five cycles, offered beat must wait
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 8'(8'h31 + i), 1'b0, 1'b0, srdy);
        end
        check_a("bp full", 1'b1, 32'h34333231, 4'hF, 1'b0, 1'b0);
        held = a_m_data;
        for (int i = 0; i < 5; i++) begin
            drive_a(1'b1, 8'hEE, 1'b0, 1'b0, srdy);
            check($sformatf("bp%0d s_ready", i), 64'(srdy), 64'd0);
            check($sformatf("bp%0d m_data", i), 64'(a_m_data), 64'(held));
            check($sformatf("bp%0d m_valid", i), 64'(a_m_valid), 64'd1);
        end
        drive_a(1'b1, 8'h41, 1'b0, 1'b1, srdy);
        check("bp release s_ready", 64'(srdy), 64'd1);
        check_a("bp release", 1'b0, 32'h41, 4'h1, 1'b0, 1'b1);
        for (int i = 1; i < 4; i++) begin
            drive_a(1'b1, 8'(8'h41 + i), 1'b0, 1'b1, srdy);
        end
        check_a("bp next", 1'b1, 32'h44434241, 4'hF, 1'b0, 1'b0);
        drive_a(1'b0, 8'h00, 1'b0, 1'b1, srdy);

        // Reset mid-word discards the assembled lanes at once
        drive_a(1'b1, 8'h01, 1'b0, 1'b1, srdy);
        drive_a(1'b1, 8'h02, 1'b0, 1'b1, srdy);
        check("mid partial", 64'(a_partial), 64'd1);
        check("mid m_data", 64'(a_m_data), 64'h0201);
        a_s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_a("async rst", 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 8'(8'h10 + i), 1'b0, 1'b1, srdy);
        end
        check_a("post rst", 1'b1, 32'h13121110, 4'hF, 1'b0, 1'b0);
        drive_a(1'b0, 8'h00, 1'b0, 1'b1, srdy);
        a_m_ready = 1'b0;

        // RATIO=1 random stream against a scoreboard
        sent = 0;
        got = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_word = '0;
        while ((sent < 200 || sb_q.size() != 0) && cyc < 5000) begin
            b_s_valid = (sent < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
            b_s_data  = 16'($urandom);
            b_s_last  = 1'($urandom_range(0, 1));
            b_m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_stall) begin
                check("r1 hold", 64'({b_m_valid, b_m_last, b_m_data}),
                      64'({1'b1, prev_word}));
            end
            if (b_m_valid && b_m_ready) begin
                if (sb_q.size() == 0) begin
                    check("r1 unexpected word", 64'd1, 64'd0);
                end else begin
                    exp_item = sb_q.pop_front();
                    check("r1 m_data", 64'(b_m_data), 64'(exp_item[15:0]));
                    check("r1 m_last", 64'(b_m_last), 64'(exp_item[16]));
                    check("r1 m_keep", 64'(b_m_keep), 64'd1);
                    got++;
                end
            end
            if (b_s_valid && b_s_ready) begin
                sb_q.push_back({b_s_last, b_s_data});
                sent++;
            end
            prev_stall = b_m_valid && !b_m_ready;
            prev_word  = {b_m_last, b_m_data};
            @(posedge clk);
            #1;
            cyc++;
        end
        check("r1 budget", 64'(cyc < 5000), 64'd1);
        check("r1 words", 64'(got), 64'd200);
        check("r1 queue empty", 64'(sb_q.size()), 64'd0);
        b_s_valid = 1'b0;
        b_m_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
